data_sram_responder: RTL

- Memory-side responder for the data SRAM interface that exe_stage drives: data_sram_en / data_sram_wen / data_sram_addr / data_sram_wdata.
- Returns data_sram_rdata one cycle after a read, which is the timing mem_stage consumes.
- Stores pass through a one-entry write buffer with byte-granular read forwarding. This takes the array write off the request cycle.
- Used as the behavioural data memory in the CPU top-level sim and as the backing store behind the SRAM-to-bus bridge.

---
 rtl/data_sram_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder: behavioural data SRAM with a one-word write buffer.
// Reads return data one cycle after the request. Stores wait in a one-entry
// buffer and reach the array on a later cycle. Reads see buffered bytes
// through byte-granular forwarding.
module data_sram_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_sram_en,
    input  logic [3:0]           data_sram_wen,
    input  logic [31:0]          data_sram_addr,
    input  logic [31:0]          data_sram_wdata,
    output logic [31:0]          data_sram_rdata,
    output logic                 wb_pending,
    output logic                 err_oob,
    output logic [CNT_WIDTH-1:0] rd_cnt,
    output logic [CNT_WIDTH-1:0] wr_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem_q [DEPTH];

    logic                  buf_valid_q, buf_valid_d;
    logic [ADDR_WIDTH-1:0] buf_idx_q,   buf_idx_d;
    logic [3:0]            buf_mask_q,  buf_mask_d;
    logic [31:0]           buf_data_q,  buf_data_d;

    logic [31:0]           rdata_q,  rdata_d;
    logic                  err_q,    err_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;

    logic [ADDR_WIDTH-1:0] idx_c;
    logic                  oob_c;
    logic                  rd_c;
    logic                  wr_c;
    logic                  hit_c;
    logic                  drain_c;
    logic [31:0]           fwd_c;
    logic                  unused_addr_c;

    assign idx_c         = data_sram_addr[ADDR_WIDTH+1:2];
    assign oob_c         = |data_sram_addr[31:ADDR_WIDTH+2];
    assign unused_addr_c = ^data_sram_addr[1:0];
    assign rd_c          = data_sram_en && (data_sram_wen == 4'b0000) && !oob_c;
    assign wr_c          = data_sram_en && (data_sram_wen != 4'b0000) && !oob_c;
    assign hit_c         = buf_valid_q && (buf_idx_q == idx_c);
    // The buffer drains on every cycle except one that merges into the same entry.
    assign drain_c       = buf_valid_q && !(wr_c && hit_c);

    // Array word overlaid with any buffered bytes for the same index.
    always_comb begin
        fwd_c = mem_q[idx_c];
        for (int i = 0; i < 4; i++) begin
            if (hit_c && buf_mask_q[i]) begin
                fwd_c[8*i +: 8] = buf_data_q[8*i +: 8];
            end
        end
    end

    // Write buffer next state: merge, capture or drain.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_idx_d   = buf_idx_q;
        buf_mask_d  = buf_mask_q;
        buf_data_d  = buf_data_q;
        if (wr_c) begin
            buf_valid_d = 1'b1;
            if (hit_c) begin
                buf_mask_d = buf_mask_q | data_sram_wen;
                for (int i = 0; i < 4; i++) begin
                    if (data_sram_wen[i]) begin
                        buf_data_d[8*i +: 8] = data_sram_wdata[8*i +: 8];
                    end
                end
            end else begin
                buf_idx_d  = idx_c;
                buf_mask_d = data_sram_wen;
                for (int i = 0; i < 4; i++) begin
                    buf_data_d[8*i +: 8] = data_sram_wen[i] ? data_sram_wdata[8*i +: 8] : 8'h00;
                end
            end
        end else if (buf_valid_q) begin
            buf_valid_d = 1'b0;
        end
    end

    // Read data, sticky error flag and saturating access counters.
    always_comb begin
        rdata_d  = rdata_q;
        err_d    = err_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (data_sram_en && (data_sram_wen == 4'b0000)) begin
            rdata_d = oob_c ? 32'h0 : fwd_c;
        end
        if (data_sram_en && oob_c) begin
            err_d = 1'b1;
        end
        if (rd_c && (rd_cnt_q != {CNT_WIDTH{1'b1}})) begin
            rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
        end
        if (wr_c && (wr_cnt_q != {CNT_WIDTH{1'b1}})) begin
            wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Control and buffer registers; pending buffer data is dropped on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_idx_q   <= '0;
            buf_mask_q  <= 4'b0000;
            buf_data_q  <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_idx_q   <= buf_idx_d;
            buf_mask_q  <= buf_mask_d;
            buf_data_q  <= buf_data_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    // Single array write port, used only by the buffer drain.
    always_ff @(posedge clk) begin
        if (drain_c) begin
            for (int i = 0; i < 4; i++) begin
                if (buf_mask_q[i]) begin
                    mem_q[buf_idx_q][8*i +: 8] <= buf_data_q[8*i +: 8];
                end
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign wb_pending      = buf_valid_q;
    assign err_oob         = err_q;
    assign rd_cnt          = rd_cnt_q;
    assign wr_cnt          = wr_cnt_q;

endmodule
